// File: rtl/bn_mean_ctrl_if.sv
// Handshake and datapath bundle between bn_mean_ctrl and its environment.
// Both streams use valid/ready: a transfer happens on the rising edge where valid && ready.
interface bn_mean_ctrl_if #(
  parameter int GRP_W = 8
);
  logic             start;
  logic [GRP_W-1:0] cfg_groups;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic [127:0]     avg_in;
  logic [7:0]       avg_mean;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_last;
  logic             done;

  modport master (
    output start, cfg_groups, s_valid, s_data, avg_mean, m_ready,
    input  busy, s_ready, avg_in, m_valid, m_data, m_last, done
  );

  modport slave (
    input  start, cfg_groups, s_valid, s_data, avg_mean, m_ready,
    output busy, s_ready, avg_in, m_valid, m_data, m_last, done
  );
endinterface

// File: rtl/bn_mean_ctrl.sv
// Collects 16-sample groups into a packed vector for an external mean datapath and
// returns one registered mean per group, for cfg_groups groups per frame.
module bn_mean_ctrl #(
  parameter int GRP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  bn_mean_ctrl_if.slave     bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       idx;
  logic [GRP_W-1:0] grp_cnt;
  logic [GRP_W-1:0] grp_last;
  logic [127:0]     avg_q;
  logic [7:0]       m_data_q;
  logic             done_q;

  logic             s_fire;
  logic             m_fire;
  logic             start_fire;
  logic             last_grp;
  logic             busy_c;
  logic             s_ready_c;
  logic             m_valid_c;
  logic             m_last_c;

  assign start_fire = (state == IDLE) && bus.start;
  assign s_fire     = (state == FILL) && bus.s_valid;
  assign m_fire     = (state == OUT) && bus.m_ready;
  assign last_grp   = (grp_cnt == grp_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = FILL;
      end
      FILL: begin
        busy_c    = 1'b1;
        s_ready_c = 1'b1;
        if (s_fire && (idx == 4'd15)) state_nxt = CALC;
      end
      CALC: begin
        busy_c    = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy_c    = 1'b1;
        m_valid_c = 1'b1;
        m_last_c  = last_grp;
        if (bus.m_ready) state_nxt = last_grp ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cfg_groups-1 wraps 0 to all ones, so a zero count runs 2^GRP_W groups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 4'd0;
      grp_cnt  <= '0;
      grp_last <= '0;
      avg_q    <= '0;
      m_data_q <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_fire) begin
        grp_last <= bus.cfg_groups - GRP_W'(1);
        grp_cnt  <= '0;
        idx      <= 4'd0;
      end
      if (s_fire) begin
        avg_q[{idx, 3'b000} +: 8] <= bus.s_data;
        idx                       <= idx + 4'd1;
      end
      if (state == CALC) begin
        m_data_q <= bus.avg_mean;
      end
      if (m_fire) begin
        idx <= 4'd0;
        if (last_grp) begin
          done_q <= 1'b1;
        end else begin
          grp_cnt <= grp_cnt + GRP_W'(1);
        end
      end
    end
  end

  assign bus.busy    = busy_c;
  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_last  = m_last_c;
  assign bus.m_data  = m_data_q;
  assign bus.avg_in  = avg_q;
  assign bus.done    = done_q;
  assign fsm_state   = state;

endmodule
